// File: rtl/display_tx_pkg.sv
// Shared LC-3 display I/O definitions: register addresses, DSR bit positions
// and the transmitter state encoding.
package display_tx_pkg;

  localparam logic [15:0] DSR_ADDR      = 16'hFE04;
  localparam logic [15:0] DDR_ADDR      = 16'hFE06;
  localparam int unsigned DSR_READY_BIT = 15;
  localparam int unsigned DSR_IE_BIT    = 14;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/display_tx_register.sv
// Generic synchronous-reset holding register with write enable.
module register #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q_o <= '0;
    end else if (wr_en) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/display_tx.sv
// LC-3 display device: DDR writes are sent as 8N1 frames on tx_o; DSR exposes
// ready/ie and irq_o raises when the line is idle with interrupts enabled.
module display_tx
  import display_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ddr_wr_en,
  input  logic [15:0] ddr_d_i,
  input  logic        dsr_wr_en,
  input  logic [15:0] dsr_d_i,
  output logic [15:0] dsr_d_o,
  output logic [15:0] ddr_d_o,
  output logic        irq_o,
  output logic        tx_o
);

  localparam int unsigned    TW     = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0]  T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0]  T_ONE  = TW'(1);

  tx_state_e     state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    idx_q, idx_d;
  logic          ie_q;
  logic          irq_q;
  logic          ready;
  logic          ddr_load;
  logic          bit_end;
  logic [7:0]    char_q;
  logic          unused_bits;

  // Ready is simply "line idle", so it can never disagree with the FSM.
  assign ready    = (state_q == ST_IDLE);
  assign ddr_load = ddr_wr_en & ready;
  assign bit_end  = (timer_q == T_LAST);

  register #(.W(8)) u_ddr (
    .clk   (clk),
    .rst   (rst),
    .wr_en (ddr_load),
    .d_i   (ddr_d_i[7:0]),
    .q_o   (char_q)
  );

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    unique case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        idx_d   = '0;
        if (ddr_wr_en) state_d = ST_START;
      end
      ST_START: begin
        timer_d = bit_end ? '0 : timer_q + T_ONE;
        if (bit_end) begin
          state_d = ST_DATA;
          idx_d   = '0;
        end
      end
      ST_DATA: begin
        timer_d = bit_end ? '0 : timer_q + T_ONE;
        if (bit_end) begin
          if (idx_q == 3'd7) state_d = ST_STOP;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      ST_STOP: begin
        timer_d = bit_end ? '0 : timer_q + T_ONE;
        if (bit_end) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      ie_q    <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      irq_q   <= ready & ie_q;
      if (dsr_wr_en) ie_q <= dsr_d_i[DSR_IE_BIT];
    end
  end

  // Line level is decoded from state so reset forces idle-high on the same edge.
  always_comb begin
    tx_o = 1'b1;
    unique case (state_q)
      ST_START: tx_o = 1'b0;
      ST_DATA:  tx_o = char_q[idx_q];
      default:  tx_o = 1'b1;
    endcase
  end

  always_comb begin
    dsr_d_o                = '0;
    dsr_d_o[DSR_READY_BIT] = ready;
    dsr_d_o[DSR_IE_BIT]    = ie_q;
  end

  assign ddr_d_o     = {8'h00, char_q};
  assign irq_o       = irq_q;
  assign unused_bits = ^{ddr_d_i[15:8], dsr_d_i[15], dsr_d_i[13:0]};

endmodule

// File: tb/tb_display_tx.sv
// Self-checking bench for display_tx: a cycle-count frame model predicts the
// line, DSR, DDR and irq every cycle, alongside fixed spec waveforms.
module tb_display_tx;

  localparam int unsigned C     = 4;
  localparam int          FRAME = 10 * C;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ddr_wr_en = 1'b0;
  logic [15:0] ddr_d_i = '0;
  logic        dsr_wr_en = 1'b0;
  logic [15:0] dsr_d_i = '0;
  logic [15:0] dsr_d_o;
  logic [15:0] ddr_d_o;
  logic        irq_o;
  logic        tx_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  display_tx #(.CLKS_PER_BIT(C)) dut (
    .clk       (clk),
    .rst       (rst),
    .ddr_wr_en (ddr_wr_en),
    .ddr_d_i   (ddr_d_i),
    .dsr_wr_en (dsr_wr_en),
    .dsr_d_i   (dsr_d_i),
    .dsr_d_o   (dsr_d_o),
    .ddr_d_o   (ddr_d_o),
    .irq_o     (irq_o),
    .tx_o      (tx_o)
  );

  // Reference model: a frame is "busy" cycles remaining; line level is the
  // frame bit selected by elapsed time.
  int         busy   = 0;
  logic [7:0] m_char = '0;
  logic       m_ie   = 1'b0;
  logic       m_irq  = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      busy   = 0;
      m_char = '0;
      m_ie   = 1'b0;
      m_irq  = 1'b0;
    end else begin
      m_irq = (busy == 0) && m_ie;
      if (dsr_wr_en) m_ie = dsr_d_i[14];
      if (busy > 0) busy = busy - 1;
      else if (ddr_wr_en) begin
        m_char = ddr_d_i[7:0];
        busy   = FRAME;
      end
    end
  end

  function automatic logic exp_tx();
    int b;
    if (busy == 0) return 1'b1;
    b = (FRAME - busy) / C;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return m_char[b-1];
  endfunction

  function automatic logic [33:0] exp_vec();
    return {exp_tx(), m_irq, (busy == 0), m_ie, 14'b0, 8'h00, m_char};
  endfunction

  function automatic logic [33:0] obs_vec();
    return {tx_o, irq_o, dsr_d_o, ddr_d_o};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({tx_o, irq_o, dsr_d_o, ddr_d_o} !== {1'b1, 1'b0, 16'h8000, 16'h0000}) begin
      n_fail++;
      $display("FAIL reset: got tx=%b irq=%b dsr=%h ddr=%h, exp tx=1 irq=0 dsr=8000 ddr=0000",
               tx_o, irq_o, dsr_d_o, ddr_d_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_frame();
    logic [9:0] pat;
    pat = 10'b1010000010;  // 'A' = 0x41, index = bit slot
    ddr_wr_en = 1'b1; ddr_d_i = 16'h0041;
    for (int i = 0; i <= FRAME + 2; i++) begin
      @(negedge clk);
      ddr_wr_en = 1'b0;
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL single_frame model i=%0d got %h exp %h", i, obs_vec(), exp_vec());
      end
      if (i < FRAME) begin
        n_checks++;
        if ({tx_o, dsr_d_o} !== {pat[i / C], 16'h0000}) begin
          n_fail++;
          $display("FAIL single_frame wave i=%0d got tx=%b dsr=%h exp tx=%b dsr=0000",
                   i, tx_o, dsr_d_o, pat[i / C]);
        end
      end else begin
        n_checks++;
        if ({tx_o, dsr_d_o, ddr_d_o} !== {1'b1, 16'h8000, 16'h0041}) begin
          n_fail++;
          $display("FAIL single_frame idle i=%0d got tx=%b dsr=%h ddr=%h exp 1/8000/0041",
                   i, tx_o, dsr_d_o, ddr_d_o);
        end
      end
    end
  endtask

  task automatic test_overrun_back_to_back();
    ddr_wr_en = 1'b1; ddr_d_i = 16'h0041;
    for (int i = 0; i <= 2 * FRAME + 3; i++) begin
      @(negedge clk);
      ddr_wr_en = 1'b0;
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL overrun model i=%0d got %h exp %h", i, obs_vec(), exp_vec());
      end
      if (i == 12 || i == FRAME - 1) begin
        n_checks++;
        if ({dsr_d_o, ddr_d_o} !== {16'h0000, 16'h0041}) begin
          n_fail++;
          $display("FAIL overrun ignored i=%0d got dsr=%h ddr=%h exp 0000/0041", i, dsr_d_o, ddr_d_o);
        end
      end
      if (i == FRAME + 1) begin
        n_checks++;
        if ({tx_o, dsr_d_o, ddr_d_o} !== {1'b0, 16'h0000, 16'h0055}) begin
          n_fail++;
          $display("FAIL back_to_back start got tx=%b dsr=%h ddr=%h exp 0/0000/0055",
                   tx_o, dsr_d_o, ddr_d_o);
        end
      end
      if (i == 9 || i == FRAME) begin
        ddr_wr_en = 1'b1; ddr_d_i = 16'h0055;
      end
    end
  endtask

  task automatic test_irq();
    dsr_wr_en = 1'b1; dsr_d_i = 16'h4000;
    @(negedge clk);
    dsr_wr_en = 1'b0;
    n_checks++;
    if ({dsr_d_o, irq_o} !== {16'hC000, 1'b0}) begin
      n_fail++;
      $display("FAIL irq ie_set got dsr=%h irq=%b exp C000/0", dsr_d_o, irq_o);
    end
    @(negedge clk);
    n_checks++;
    if (irq_o !== 1'b1) begin
      n_fail++;
      $display("FAIL irq rise got %b exp 1", irq_o);
    end
    ddr_wr_en = 1'b1; ddr_d_i = 16'h0023;
    for (int i = 0; i <= FRAME + 2; i++) begin
      @(negedge clk);
      ddr_wr_en = 1'b0;
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL irq model i=%0d got %h exp %h", i, obs_vec(), exp_vec());
      end
      if (i == 5 || i == FRAME || i == FRAME + 1) begin
        n_checks++;
        if (irq_o !== (i == FRAME + 1)) begin
          n_fail++;
          $display("FAIL irq frame i=%0d got %b exp %b", i, irq_o, (i == FRAME + 1));
        end
      end
    end
    dsr_wr_en = 1'b1; dsr_d_i = 16'h0000;
    @(negedge clk);
    dsr_wr_en = 1'b0;
  endtask

  task automatic test_reset_midframe();
    ddr_wr_en = 1'b1; ddr_d_i = 16'h0033;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      ddr_wr_en = 1'b0;
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL rst_mid pre i=%0d got %h exp %h", i, obs_vec(), exp_vec());
      end
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({tx_o, irq_o, dsr_d_o, ddr_d_o} !== {1'b1, 1'b0, 16'h8000, 16'h0000}) begin
      n_fail++;
      $display("FAIL rst_mid abort got tx=%b irq=%b dsr=%h ddr=%h exp 1/0/8000/0000",
               tx_o, irq_o, dsr_d_o, ddr_d_o);
    end
    ddr_wr_en = 1'b1; ddr_d_i = 16'h005A;
    for (int i = 0; i <= FRAME + 1; i++) begin
      @(negedge clk);
      ddr_wr_en = 1'b0;
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL rst_mid post i=%0d got %h exp %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_same_cycle();
    dsr_wr_en = 1'b1; dsr_d_i = 16'h4000;
    ddr_wr_en = 1'b1; ddr_d_i = 16'h00FF;
    for (int i = 0; i <= FRAME + 1; i++) begin
      @(negedge clk);
      dsr_wr_en = 1'b0; ddr_wr_en = 1'b0;
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL same_cycle model i=%0d got %h exp %h", i, obs_vec(), exp_vec());
      end
      if (i < FRAME) begin
        n_checks++;
        if ({tx_o, dsr_d_o} !== {(i >= C), 16'h4000}) begin
          n_fail++;
          $display("FAIL same_cycle wave i=%0d got tx=%b dsr=%h exp tx=%b dsr=4000",
                   i, tx_o, dsr_d_o, (i >= C));
        end
      end
    end
    dsr_wr_en = 1'b1; dsr_d_i = 16'h0000;
    @(negedge clk);
    dsr_wr_en = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random i=%0d got %h exp %h", i, obs_vec(), exp_vec());
      end
      ddr_wr_en = ($urandom_range(0, 7) == 0);
      ddr_d_i   = 16'($urandom);
      dsr_wr_en = ($urandom_range(0, 19) == 0);
      dsr_d_i   = 16'($urandom);
      rst       = ($urandom_range(0, 499) == 0);
    end
    rst = 1'b0; ddr_wr_en = 1'b0; dsr_wr_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_overrun_back_to_back();
    repeat (FRAME + 2) @(negedge clk);
    test_irq();
    test_reset_midframe();
    test_same_cycle();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
